router_in_port: RTL and testbench
=================================

// Module: router_in_port
// PURPOSE
//  Router-side receiver for one node link, directly downstream of the node's byte-serial sender.
//  Reassembles the 4-byte transfer (MSB first) into a 32-bit pkt_t and buffers packets in a DEPTH-entry FIFO.
//  Presents the head packet and its destination to the router crossbar, which pops it with a grant.
//  Throttles the sender with the free line, so the sender never starts a packet it cannot finish.
// PARAMETERS
//  DEPTH   4   packet FIFO entries (power of 2, >=2)
//  PORTID  0   node/port number, used only for the bounce check
// PORTS
//  clock       in   1   single clock; all state on posedge
//  reset       in   1   asynchronous, active-high reset
//  put         in   1   sender drives a valid byte this cycle
//  payload     in   8   byte from sender
//  free        out  1   registered; 1 = a new packet may start
//  head_valid  out  1   FIFO not empty
//  head_pkt    out  32  pkt_t at FIFO head, combinational from storage
//  head_dest   out  4   head_pkt.dest
//  grant       in   1   crossbar took head this cycle (pop)
//  count       out  $clog2(DEPTH)+1  packets stored
//  proto_err   out  1   sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset (async, active-high)
//   - Outputs: free=1, head_valid=0, count=0, proto_err=0.
//   - Internal state: byte_cnt=0, pointers=0, FSM=IDLE. Shift register and storage contents are don't-care.
//  FSM states: IDLE and RECV.
//   - IDLE, put=1, free=1: capture byte0 into sh[31:24], byte_cnt=1, go to RECV.
//   - RECV, put=1: capture the byte at sh[31-8*byte_cnt -: 8] and increment byte_cnt.
//     On the 4th byte, write {sh[31:8],payload} to the FIFO at that same edge, byte_cnt=0, go to IDLE.
//   - RECV, put=0: hold state. Gaps between bytes are legal, and no timeout applies.
//   - IDLE, put=1, free=0: protocol violation. Set proto_err, drop the byte, stay in IDLE.
//  free rule (registered)
//   - free_next = (state_next==IDLE) && (count_next < DEPTH).
//   - free drops the cycle after byte0 is accepted.
//   - free rises the cycle after byte3, if a slot remains.
//  Latency: byte3 sampled at edge N; head_valid=1 at edge N if the FIFO was empty, so the packet is visible in cycle N+1.
//  Pop: grant && head_valid advances rd_ptr. grant while empty is ignored and never sets an error.
//  Simultaneous push and pop
//   - Both take effect and count is unchanged.
//   - Legal at count==DEPTH, because free already guaranteed the slot before byte0 was accepted.
//  Wrap-around: pointers are $clog2(DEPTH)+1 bits. full = MSBs differ and lower bits are equal; empty = pointers equal.
//  Bounce check: a completed packet with dest==PORTID is still stored (the crossbar decides), but sets proto_err.
//  Reset mid-packet: any partial packet is discarded. Bytes arriving after reset deassertion are treated as a new packet.
// STRUCTURE
//  RouterPkg
//   - pkt_t = {src[3:0], dest[3:0], data[23:0]}.
//   - BYTES_PER_PKT=4.
//   - rx_state_t enum {IDLE,RECV}.
//  Sub-module pkt_fifo #(DEPTH)
//   - Pointer-based buffer, not shift-based; writes and pops are on the clock edge.
//   - Combinational head read.
//   - Ports: push/pop/din/dout/count/full/empty.
//  The top level holds the FSM, shift register, free register and error logic.
// TESTING
//  1. Reset, then idle 5 cycles -> free=1, head_valid=0, count=0, proto_err=0.
//  2. put 4 cycles with 12,34,56,78 (PORTID=0)
//     -> head_pkt=32'h12345678 and head_dest=2 in the cycle after byte3.
//     -> free low from the cycle after byte0; high again after byte3.
//  3. Send 4 packets with no grant (DEPTH=4) -> count=4, free stays 0. Grant x4 -> packets pop in order, free=1.
//  4. count=3, 4th packet in flight, grant asserted on the same edge as byte3 -> count stays 3, free=1 the next cycle.
//  5. put=1 while free=0 in IDLE -> proto_err=1, count unchanged. Reset -> proto_err=0.
//  6. Assert reset after byte1 of A1,B2,C3,D4, then send 0F,00,00,01
//     -> one packet, 32'h0F000001; no trace of A1B2 in the FIFO.

Source files
------------

// File: rtl/router_in_port_pkg.sv
// Shared types for the router input port: packet layout and receiver states.
package router_in_port_pkg;

    localparam int BYTES_PER_PKT = 4;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic {
        IDLE,
        RECV
    } rx_state_t;

endpackage

// File: rtl/router_in_port_if.sv
// Link from the byte-serial sender plus the head/grant path to the crossbar.
interface router_in_port_if
    import router_in_port_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          put;
    logic [7:0]    payload;
    logic          free;
    logic          head_valid;
    pkt_t          head_pkt;
    logic [3:0]    head_dest;
    logic          grant;
    logic [CW-1:0] count;
    logic          proto_err;

    modport master (
        output put, payload, grant,
        input  free, head_valid, head_pkt, head_dest, count, proto_err
    );

    modport slave (
        input  put, payload, grant,
        output free, head_valid, head_pkt, head_dest, count, proto_err
    );

endinterface

// File: rtl/router_in_port_pkt_fifo.sv
// Pointer-based packet FIFO with a combinational head read.
module pkt_fifo
    import router_in_port_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  pkt_t          din,
    output pkt_t          dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    pkt_t        mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    // Extra pointer bit tells a wrapped (full) FIFO from an empty one
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/router_in_port.sv
// Router input port: reassembles 4-byte packets, buffers them, throttles the sender.
module router_in_port
    import router_in_port_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PORTID = 0
) (
    input  logic clock,
    input  logic reset,
    router_in_port_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [1:0] LAST = 2'(BYTES_PER_PKT - 1);

    rx_state_t     state;
    rx_state_t     state_next;
    logic [1:0]    byte_cnt;
    logic [23:0]   sh;
    logic          free_q;
    logic          err_q;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] fcount;
    logic [CW-1:0] count_next;
    pkt_t          pkt_w;
    pkt_t          head;

    assign pkt_w = {sh, bus.payload};
    assign pop   = bus.grant && !empty;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        unique case (state)
            IDLE: if (bus.put && free_q) state_next = RECV;
            RECV: if (bus.put && byte_cnt == LAST) begin
                state_next = IDLE;
                push       = !full || pop;
            end
            default: state_next = IDLE;
        endcase
    end

    assign count_next = fcount + CW'(push) - CW'(pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            sh       <= '0;
            free_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state  <= state_next;
            free_q <= (state_next == IDLE) && (count_next < CW'(DEPTH));
            unique case (state)
                IDLE: if (bus.put) begin
                    if (free_q) begin
                        sh[23:16] <= bus.payload;
                        byte_cnt  <= 2'd1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                RECV: if (bus.put) begin
                    byte_cnt <= (byte_cnt == LAST) ? 2'd0 : byte_cnt + 2'd1;
                    if (byte_cnt == 2'd1) sh[15:8] <= bus.payload;
                    if (byte_cnt == 2'd2) sh[7:0]  <= bus.payload;
                    // Bounced packet is still stored; only flagged
                    if (byte_cnt == LAST && pkt_w.dest == 4'(PORTID))
                        err_q <= 1'b1;
                end
                default: byte_cnt <= '0;
            endcase
        end
    end

    pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pkt_w),
        .dout  (head),
        .count (fcount),
        .full  (full),
        .empty (empty)
    );

    assign bus.free       = free_q;
    assign bus.head_valid = !empty;
    assign bus.head_pkt   = head;
    assign bus.head_dest  = head.dest;
    assign bus.count      = fcount;
    assign bus.proto_err  = err_q;

endmodule

// File: tb/tb_router_in_port.sv
// Scoreboard bench for router_in_port: directed packets, pops checked by a monitor.
module tb_router_in_port;
    import router_in_port_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errs  = 0;
    int   nchk  = 0;
    pkt_t sb[$];

    always #5 clock = ~clock;

    router_in_port_if #(.DEPTH(4)) bus ();

    router_in_port #(.DEPTH(4), .PORTID(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops happen at the next posedge whenever grant meets a valid head
    always @(negedge clock) begin
        if (!reset && bus.grant && bus.head_valid) begin
            if (sb.size() == 0) begin
                nchk++;
                errs++;
                $display("FAIL pop_unexpected: got %h expected none",
                         bus.head_pkt);
            end else begin
                pkt_t e;
                e = sb.pop_front();
                chk("pop_pkt", bus.head_pkt, e);
                chk("pop_dest", 32'(bus.head_dest), 32'(e.dest));
            end
        end
    end

    task automatic cyc(input logic p, input logic [7:0] b, input logic g);
        bus.put     = p;
        bus.payload = b;
        bus.grant   = g;
        @(negedge clock);
        @(posedge clock);
        #1;
        bus.put   = 1'b0;
        bus.grant = 1'b0;
    endtask

    task automatic send(input logic [31:0] p, input logic g3);
        sb.push_back(pkt_t'(p));
        cyc(1'b1, p[31:24], 1'b0);
        cyc(1'b1, p[23:16], 1'b0);
        cyc(1'b1, p[15:8], 1'b0);
        cyc(1'b1, p[7:0], g3);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.put     = 1'b0;
        bus.payload = 8'h00;
        bus.grant   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) cyc(1'b0, 8'h00, 1'b0);
        chk("rst_free", 32'(bus.free), 32'd1);
        chk("rst_hv", 32'(bus.head_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_err", 32'(bus.proto_err), 32'd0);

        // Single packet, latency and free timing
        sb.push_back(pkt_t'(32'h12345678));
        cyc(1'b1, 8'h12, 1'b0);
        chk("p1_free_b0", 32'(bus.free), 32'd0);
        cyc(1'b1, 8'h34, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("p1_gap_hv", 32'(bus.head_valid), 32'd0);
        cyc(1'b1, 8'h56, 1'b0);
        cyc(1'b1, 8'h78, 1'b0);
        chk("p1_hv", 32'(bus.head_valid), 32'd1);
        chk("p1_pkt", bus.head_pkt, 32'h12345678);
        chk("p1_dest", 32'(bus.head_dest), 32'd2);
        chk("p1_free", 32'(bus.free), 32'd1);
        chk("p1_count", 32'(bus.count), 32'd1);
        drain(1);
        chk("p1_empty", 32'(bus.count), 32'd0);

        // Fill to DEPTH, then pop in order
        send(32'h1A000001, 1'b0);
        send(32'h2B000002, 1'b0);
        send(32'h3C000003, 1'b0);
        send(32'h4D000004, 1'b0);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_free", 32'(bus.free), 32'd0);
        chk("fill_err", 32'(bus.proto_err), 32'd0);
        drain(1);
        chk("pop1_free", 32'(bus.free), 32'd1);
        drain(3);
        chk("drain_count", 32'(bus.count), 32'd0);

        // Push and pop on the same edge with count==3
        send(32'h51000011, 1'b0);
        send(32'h52000012, 1'b0);
        send(32'h53000013, 1'b0);
        chk("c3_count", 32'(bus.count), 32'd3);
        chk("c3_free", 32'(bus.free), 32'd1);
        send(32'h54000014, 1'b1);
        chk("pp_count", 32'(bus.count), 32'd3);
        chk("pp_free", 32'(bus.free), 32'd1);
        drain(3);

        // Grant while empty is ignored
        drain(2);
        chk("ge_count", 32'(bus.count), 32'd0);
        chk("ge_err", 32'(bus.proto_err), 32'd0);

        // Put while not free
        send(32'h61000021, 1'b0);
        send(32'h62000022, 1'b0);
        send(32'h63000023, 1'b0);
        send(32'h64000024, 1'b0);
        cyc(1'b1, 8'h99, 1'b0);
        chk("viol_err", 32'(bus.proto_err), 32'd1);
        chk("viol_count", 32'(bus.count), 32'd4);
        do_reset();
        chk("viol_rst_err", 32'(bus.proto_err), 32'd0);
        chk("viol_rst_count", 32'(bus.count), 32'd0);

        // Reset mid-packet discards the partial packet
        cyc(1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0);
        do_reset();
        chk("mid_free", 32'(bus.free), 32'd1);
        send(32'h0F000001, 1'b0);
        chk("mid_count", 32'(bus.count), 32'd1);
        chk("mid_pkt", bus.head_pkt, 32'h0F000001);
        drain(1);
        chk("mid_empty", 32'(bus.count), 32'd0);

        // Bounce: dest equals own port id
        send(32'h10050607, 1'b0);
        chk("bnc_err", 32'(bus.proto_err), 32'd1);
        chk("bnc_count", 32'(bus.count), 32'd1);
        drain(1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
